// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Data-memory access controller for the MIPS core. It steers each CPU
// load/store to the internal synchronous RAM (0x500-0x8FF) or to the
// external req/ack bus. The CPU sees one Ready pulse per access. Fault
// accompanies Ready when an external access timed out.
//
// Ports
//   CLK, Reset           clock, asynchronous active-high reset
//   Address/WData/We/Req CPU request, held while Req is high
//   CS_n                 decoder select, 0 = internal RAM, 1 = external bus
//   RData/Ready/Fault    registered completion signals to the CPU
//   Stall                Req & ~Ready, combinational
//   RamAddr/RamWe/RamWData/RamRData   internal synchronous RAM port
//   ExtReq/ExtWe/ExtAddr/ExtWData/ExtRData/ExtAck   external bus handshake
module mem_access_ctrl #(
    parameter int          DATA_W      = 32,
    parameter logic [15:0] RAM_BASE    = 16'h0500,
    parameter int          EXT_TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [15:0]       Address,
    input  logic [DATA_W-1:0] WData,
    input  logic              We,
    input  logic              Req,
    input  logic              CS_n,
    output logic [DATA_W-1:0] RData,
    output logic              Ready,
    output logic              Fault,
    output logic              Stall,
    output logic [9:0]        RamAddr,
    output logic              RamWe,
    output logic [DATA_W-1:0] RamWData,
    input  logic [DATA_W-1:0] RamRData,
    output logic              ExtReq,
    output logic              ExtWe,
    output logic [15:0]       ExtAddr,
    output logic [DATA_W-1:0] ExtWData,
    input  logic [DATA_W-1:0] ExtRData,
    input  logic              ExtAck
);

    localparam int             CNT_W    = $clog2(EXT_TIMEOUT + 1);
    // Count value seen during the last permitted ExtReq cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INT_ADDR,
        S_INT_DATA,
        S_EXT_WAIT,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               we_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               ready_q;
    logic               fault_q;
    logic [9:0]         ram_addr_q;
    logic               ram_we_q;
    logic [DATA_W-1:0]  ram_wdata_q;
    logic               ext_req_q;
    logic               ext_we_q;
    logic [15:0]        ext_addr_q;
    logic [DATA_W-1:0]  ext_wdata_q;

    // Only the low 10 bits of the offset matter; subtracting the low bits
    // alone gives the same index modulo 1024.
    logic [9:0] ram_idx_d;
    assign ram_idx_d = Address[9:0] - RAM_BASE[9:0];

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
        end else begin
            // The RAM write strobe lives for the INT_ADDR cycle only.
            ram_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Req) begin
                        we_q  <= We;
                        cnt_q <= '0;
                        // Routing is decided here once; CS_n is not looked at again.
                        if (!CS_n) begin
                            ram_addr_q  <= ram_idx_d;
                            ram_we_q    <= We;
                            ram_wdata_q <= WData;
                            state_q     <= S_INT_ADDR;
                        end else begin
                            ext_req_q   <= 1'b1;
                            ext_we_q    <= We;
                            ext_addr_q  <= Address;
                            ext_wdata_q <= WData;
                            state_q     <= S_EXT_WAIT;
                        end
                    end
                end
                S_INT_ADDR: begin
                    state_q <= S_INT_DATA;
                end
                S_INT_DATA: begin
                    // RAM read data is valid one cycle after the address.
                    if (!we_q) begin
                        rdata_q <= RamRData;
                    end
                    ready_q <= 1'b1;
                    fault_q <= 1'b0;
                    state_q <= S_DONE;
                end
                S_EXT_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Ack wins over timeout when both land in the same cycle.
                    if (ExtAck) begin
                        if (!we_q) begin
                            rdata_q <= ExtRData;
                        end
                        ext_req_q <= 1'b0;
                        ext_we_q  <= 1'b0;
                        ready_q   <= 1'b1;
                        fault_q   <= 1'b0;
                        state_q   <= S_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        // A timed-out store is dropped; a timed-out load returns zero.
                        if (!we_q) begin
                            rdata_q <= '0;
                        end
                        ext_req_q <= 1'b0;
                        ext_we_q  <= 1'b0;
                        ready_q   <= 1'b1;
                        fault_q   <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Req and ExtAck are ignored here, so no access starts in DONE.
                    ready_q <= 1'b0;
                    fault_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign RData    = rdata_q;
    assign Ready    = ready_q;
    assign Fault    = fault_q;
    assign Stall    = Req & ~ready_q;
    assign RamAddr  = ram_addr_q;
    assign RamWe    = ram_we_q;
    assign RamWData = ram_wdata_q;
    assign ExtReq   = ext_req_q;
    assign ExtWe    = ext_we_q;
    assign ExtAddr  = ext_addr_q;
    assign ExtWData = ext_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed scenarios with a behavioural
// synchronous RAM and a hand-driven external bus.
module tb_mem_access_ctrl;

    localparam int DATA_W      = 32;
    localparam int EXT_TIMEOUT = 15;

    logic              CLK = 1'b0;
    logic              Reset;
    logic [15:0]       Address;
    logic [DATA_W-1:0] WData;
    logic              We;
    logic              Req;
    logic              CS_n;
    logic [DATA_W-1:0] RData;
    logic              Ready;
    logic              Fault;
    logic              Stall;
    logic [9:0]        RamAddr;
    logic              RamWe;
    logic [DATA_W-1:0] RamWData;
    logic [DATA_W-1:0] RamRData;
    logic              ExtReq;
    logic              ExtWe;
    logic [15:0]       ExtAddr;
    logic [DATA_W-1:0] ExtWData;
    logic [DATA_W-1:0] ExtRData;
    logic              ExtAck;

    int checks   = 0;
    int failures = 0;

    mem_access_ctrl #(
        .DATA_W     (DATA_W),
        .RAM_BASE   (16'h0500),
        .EXT_TIMEOUT(EXT_TIMEOUT)
    ) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .Address (Address),
        .WData   (WData),
        .We      (We),
        .Req     (Req),
        .CS_n    (CS_n),
        .RData   (RData),
        .Ready   (Ready),
        .Fault   (Fault),
        .Stall   (Stall),
        .RamAddr (RamAddr),
        .RamWe   (RamWe),
        .RamWData(RamWData),
        .RamRData(RamRData),
        .ExtReq  (ExtReq),
        .ExtWe   (ExtWe),
        .ExtAddr (ExtAddr),
        .ExtWData(ExtWData),
        .ExtRData(ExtRData),
        .ExtAck  (ExtAck)
    );

    always #5 CLK = ~CLK;

    // Synchronous RAM: read data valid one cycle after the address.
    logic [DATA_W-1:0] mem [0:1023];
    always @(posedge CLK) begin
        if (RamWe) mem[RamAddr] <= RamWData;
        RamRData <= mem[RamAddr];
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1; Req = 1'b0; We = 1'b0; CS_n = 1'b0;
        Address = 16'h0; WData = '0; ExtAck = 1'b0; ExtRData = '0;
        #2;
        checks++; if (RData !== 32'h0)  begin failures++; $display("FAIL reset_rdata got %h want 0", RData); end
        checks++; if (Ready !== 1'b0)   begin failures++; $display("FAIL reset_ready got %b want 0", Ready); end
        checks++; if (Fault !== 1'b0)   begin failures++; $display("FAIL reset_fault got %b want 0", Fault); end
        checks++; if (RamAddr !== 10'h0) begin failures++; $display("FAIL reset_ramaddr got %h want 0", RamAddr); end
        checks++; if (RamWe !== 1'b0)   begin failures++; $display("FAIL reset_ramwe got %b want 0", RamWe); end
        checks++; if (RamWData !== 32'h0) begin failures++; $display("FAIL reset_ramwdata got %h want 0", RamWData); end
        checks++; if (ExtReq !== 1'b0)  begin failures++; $display("FAIL reset_extreq got %b want 0", ExtReq); end
        checks++; if (ExtWe !== 1'b0)   begin failures++; $display("FAIL reset_extwe got %b want 0", ExtWe); end
        checks++; if (ExtAddr !== 16'h0) begin failures++; $display("FAIL reset_extaddr got %h want 0", ExtAddr); end
        checks++; if (ExtWData !== 32'h0) begin failures++; $display("FAIL reset_extwdata got %h want 0", ExtWData); end
        tick; tick;
        Reset = 1'b0;
        tick;
    endtask

    // Internal access; CS_n toggles after acceptance and Req is held through DONE.
    task automatic test_int_access(input string name, input logic [15:0] addr, input logic we,
                                   input logic [31:0] wdata, input logic [9:0] exp_idx,
                                   input logic [31:0] exp_rdata);
        Req = 1'b1; Address = addr; We = we; WData = wdata; CS_n = 1'b0;
        #1;
        checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL %s c0_stall got %b want 1", name, Stall); end
        tick; // cycle 1
        CS_n = 1'b1;
        checks++; if (RamWe !== we) begin failures++; $display("FAIL %s c1_ramwe got %b want %b", name, RamWe, we); end
        checks++; if (RamAddr !== exp_idx) begin failures++; $display("FAIL %s c1_ramaddr got %h want %h", name, RamAddr, exp_idx); end
        checks++; if (RamWData !== wdata) begin failures++; $display("FAIL %s c1_ramwdata got %h want %h", name, RamWData, wdata); end
        checks++; if (ExtReq !== 1'b0) begin failures++; $display("FAIL %s c1_extreq got %b want 0", name, ExtReq); end
        tick; // cycle 2
        checks++; if (RamWe !== 1'b0) begin failures++; $display("FAIL %s c2_ramwe got %b want 0", name, RamWe); end
        checks++; if (RamAddr !== exp_idx) begin failures++; $display("FAIL %s c2_ramaddr_hold got %h want %h", name, RamAddr, exp_idx); end
        checks++; if (Ready !== 1'b0) begin failures++; $display("FAIL %s c2_ready got %b want 0", name, Ready); end
        checks++; if (ExtReq !== 1'b0) begin failures++; $display("FAIL %s c2_extreq got %b want 0", name, ExtReq); end
        tick; // cycle 3: Ready
        checks++; if (Ready !== 1'b1) begin failures++; $display("FAIL %s c3_ready got %b want 1", name, Ready); end
        checks++; if (Fault !== 1'b0) begin failures++; $display("FAIL %s c3_fault got %b want 0", name, Fault); end
        checks++; if (RData !== exp_rdata) begin failures++; $display("FAIL %s c3_rdata got %h want %h", name, RData, exp_rdata); end
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL %s c3_stall got %b want 0", name, Stall); end
        tick; // cycle 4: Req still high during DONE must not have started anything
        Req = 1'b0; CS_n = 1'b0;
        checks++; if (Ready !== 1'b0) begin failures++; $display("FAIL %s c4_ready got %b want 0", name, Ready); end
        checks++; if (RamWe !== 1'b0) begin failures++; $display("FAIL %s c4_dup_ramwe got %b want 0", name, RamWe); end
        checks++; if (ExtReq !== 1'b0) begin failures++; $display("FAIL %s c4_dup_extreq got %b want 0", name, ExtReq); end
        tick;
    endtask

    // External access; ack_cyc = 0 means no ack (timeout).
    task automatic test_ext(input string name, input logic [15:0] addr, input logic we,
                            input logic [31:0] wdata, input int ack_cyc, input logic [31:0] ack_data,
                            input logic exp_fault, input logic [31:0] exp_rdata);
        int n;
        n = (ack_cyc == 0) ? EXT_TIMEOUT : ack_cyc;
        Req = 1'b1; Address = addr; We = we; WData = wdata; CS_n = 1'b1; ExtAck = 1'b0;
        #1;
        checks++; if (ExtReq !== 1'b0) begin failures++; $display("FAIL %s c0_extreq got %b want 0", name, ExtReq); end
        checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL %s c0_stall got %b want 1", name, Stall); end
        for (int c = 1; c <= n; c++) begin
            tick;
            if (c == 1) begin
                CS_n = 1'b0;
                checks++; if (ExtAddr !== addr) begin failures++; $display("FAIL %s c1_extaddr got %h want %h", name, ExtAddr, addr); end
                checks++; if (ExtWe !== we) begin failures++; $display("FAIL %s c1_extwe got %b want %b", name, ExtWe, we); end
                checks++; if (ExtWData !== wdata) begin failures++; $display("FAIL %s c1_extwdata got %h want %h", name, ExtWData, wdata); end
            end
            checks++; if (ExtReq !== 1'b1) begin failures++; $display("FAIL %s c%0d_extreq got %b want 1", name, c, ExtReq); end
            checks++; if (Ready !== 1'b0) begin failures++; $display("FAIL %s c%0d_ready got %b want 0", name, c, Ready); end
            checks++; if (RamWe !== 1'b0) begin failures++; $display("FAIL %s c%0d_ramwe got %b want 0", name, c, RamWe); end
            if (c == ack_cyc) begin
                ExtAck = 1'b1; ExtRData = ack_data;
            end
        end
        tick; // cycle n+1: DONE
        ExtAck = 1'b0; ExtRData = 32'hFFFF_FFFF;
        checks++; if (ExtReq !== 1'b0) begin failures++; $display("FAIL %s done_extreq got %b want 0", name, ExtReq); end
        checks++; if (Ready !== 1'b1) begin failures++; $display("FAIL %s done_ready got %b want 1", name, Ready); end
        checks++; if (Fault !== exp_fault) begin failures++; $display("FAIL %s done_fault got %b want %b", name, Fault, exp_fault); end
        checks++; if (RData !== exp_rdata) begin failures++; $display("FAIL %s done_rdata got %h want %h", name, RData, exp_rdata); end
        tick;
        Req = 1'b0; CS_n = 1'b1;
        checks++; if (Ready !== 1'b0) begin failures++; $display("FAIL %s after_ready got %b want 0", name, Ready); end
        checks++; if (Fault !== 1'b0) begin failures++; $display("FAIL %s after_fault got %b want 0", name, Fault); end
        checks++; if (ExtReq !== 1'b0) begin failures++; $display("FAIL %s after_extreq got %b want 0", name, ExtReq); end
        checks++; if (RamWe !== 1'b0) begin failures++; $display("FAIL %s after_ramwe got %b want 0", name, RamWe); end
        tick;
    endtask

    // Internal load, then an external store presented during DONE and kept
    // high into the following IDLE cycle, acked in its first ExtReq cycle.
    task automatic test_back_to_back;
        Req = 1'b1; Address = 16'h0500; We = 1'b0; WData = '0; CS_n = 1'b0;
        tick; tick; tick; // cycle 3
        checks++; if (Ready !== 1'b1) begin failures++; $display("FAIL b2b c3_ready got %b want 1", Ready); end
        checks++; if (RData !== 32'hDEAD_BEEF) begin failures++; $display("FAIL b2b c3_rdata got %h want deadbeef", RData); end
        Address = 16'h2000; We = 1'b1; WData = 32'hCAFE_F00D; CS_n = 1'b1;
        tick; // cycle 4: IDLE, request accepted at the end of this cycle
        checks++; if (ExtReq !== 1'b0) begin failures++; $display("FAIL b2b c4_extreq got %b want 0", ExtReq); end
        checks++; if (Ready !== 1'b0) begin failures++; $display("FAIL b2b c4_ready got %b want 0", Ready); end
        tick; // cycle 5
        checks++; if (ExtReq !== 1'b1) begin failures++; $display("FAIL b2b c5_extreq got %b want 1", ExtReq); end
        checks++; if (ExtWe !== 1'b1) begin failures++; $display("FAIL b2b c5_extwe got %b want 1", ExtWe); end
        checks++; if (ExtAddr !== 16'h2000) begin failures++; $display("FAIL b2b c5_extaddr got %h want 2000", ExtAddr); end
        checks++; if (ExtWData !== 32'hCAFE_F00D) begin failures++; $display("FAIL b2b c5_extwdata got %h want cafef00d", ExtWData); end
        ExtAck = 1'b1; ExtRData = 32'h1111_2222;
        tick; // cycle 6
        ExtAck = 1'b0;
        checks++; if (Ready !== 1'b1) begin failures++; $display("FAIL b2b c6_ready got %b want 1", Ready); end
        checks++; if (Fault !== 1'b0) begin failures++; $display("FAIL b2b c6_fault got %b want 0", Fault); end
        checks++; if (RData !== 32'hDEAD_BEEF) begin failures++; $display("FAIL b2b c6_rdata got %h want deadbeef", RData); end
        checks++; if (ExtReq !== 1'b0) begin failures++; $display("FAIL b2b c6_extreq got %b want 0", ExtReq); end
        tick;
        Req = 1'b0;
        checks++; if (Ready !== 1'b0) begin failures++; $display("FAIL b2b c7_ready got %b want 0", Ready); end
        tick;
    endtask

    task automatic test_reset_mid_ext;
        Req = 1'b1; Address = 16'h3000; We = 1'b0; WData = '0; CS_n = 1'b1; ExtAck = 1'b0;
        tick; tick; // cycle 2
        checks++; if (ExtReq !== 1'b1) begin failures++; $display("FAIL rst_mid c2_extreq got %b want 1", ExtReq); end
        Reset = 1'b1;
        #1;
        checks++; if (ExtReq !== 1'b0) begin failures++; $display("FAIL rst_mid async_extreq got %b want 0", ExtReq); end
        checks++; if (Ready !== 1'b0) begin failures++; $display("FAIL rst_mid async_ready got %b want 0", Ready); end
        checks++; if (Fault !== 1'b0) begin failures++; $display("FAIL rst_mid async_fault got %b want 0", Fault); end
        checks++; if (RData !== 32'h0) begin failures++; $display("FAIL rst_mid async_rdata got %h want 0", RData); end
        Req = 1'b0;
        tick;
        Reset = 1'b0;
        ExtAck = 1'b1; ExtRData = 32'h5555_AAAA;
        for (int c = 0; c < 4; c++) begin
            tick;
            ExtAck = 1'b0;
            checks++; if (Ready !== 1'b0) begin failures++; $display("FAIL rst_mid late_ack_ready%0d got %b want 0", c, Ready); end
            checks++; if (ExtReq !== 1'b0) begin failures++; $display("FAIL rst_mid late_ack_extreq%0d got %b want 0", c, ExtReq); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_int_access("int_st_500", 16'h0500, 1'b1, 32'hDEAD_BEEF, 10'h000, 32'h0000_0000);
        test_int_access("int_ld_500", 16'h0500, 1'b0, 32'h0000_0000, 10'h000, 32'hDEAD_BEEF);
        test_int_access("int_st_8ff", 16'h08FF, 1'b1, 32'hA5A5_5A5A, 10'h3FF, 32'hDEAD_BEEF);
        test_int_access("int_ld_8ff", 16'h08FF, 1'b0, 32'h0000_0000, 10'h3FF, 32'hA5A5_5A5A);
        test_ext("ext_ld_ack4", 16'h1234, 1'b0, 32'h0, 4, 32'h1234_5678, 1'b0, 32'h1234_5678);
        test_ext("ext_ld_tmo", 16'h4000, 1'b0, 32'h0, 0, 32'h0, 1'b1, 32'h0000_0000);
        test_ext("ext_ld_ack15", 16'h4004, 1'b0, 32'h0, EXT_TIMEOUT, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D);
        test_ext("ext_st_tmo", 16'h4008, 1'b1, 32'h7777_8888, 0, 32'h0, 1'b1, 32'h0BAD_F00D);
        test_back_to_back;
        test_reset_mid_ext;
        test_int_access("int_ld_after_rst", 16'h0500, 1'b0, 32'h0000_0000, 10'h000, 32'hDEAD_BEEF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
